// File: rtl/sqwave_ctrl.sv
// Square-wave sequencing controller: wave is high for act_m units and low for act_n units.
// New lengths pass through a one-deep pending slot and take effect only at period boundaries.
module sqwave_ctrl #(
    parameter int UNIT_CYCLES = 10,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_m,
    input  logic [CW-1:0] cfg_n,
    output logic          cfg_ready,
    output logic          wave,
    output logic          busy,
    output logic          period_tick
);

    localparam int UW = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [UW-1:0] U_ONE  = UW'(1);
    localparam logic [UW-1:0] U_ZERO = UW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t        state_r;
    logic [UW-1:0] ucnt_r;
    logic [CW-1:0] pcnt_r;
    logic [CW-1:0] act_m_r;
    logic [CW-1:0] act_n_r;
    logic [CW-1:0] pend_m_r;
    logic [CW-1:0] pend_n_r;
    logic          pend_v_r;

    logic          unit_end_s;
    logic          high_end_s;
    logic          low_end_s;
    logic          period_tick_s;
    logic          load_s;
    logic          accept_s;
    logic [CW-1:0] next_m_s;
    logic [CW-1:0] next_n_s;

    // Phase-end detection, boundary tick and pending-slot load decision
    always_comb begin
        unit_end_s    = (ucnt_r == U_LAST);
        high_end_s    = (state_r == ST_HIGH) && unit_end_s && (pcnt_r == (act_m_r - C_ONE));
        low_end_s     = (state_r == ST_LOW) && unit_end_s && (pcnt_r == (act_n_r - C_ONE));
        period_tick_s = low_end_s || (high_end_s && (act_n_r == C_ZERO));
        // A stop on the boundary cycle leaves the pending config in its slot
        load_s        = pend_v_r && ((state_r == ST_IDLE) || (period_tick_s && !stop));
        accept_s      = cfg_valid && !pend_v_r;
        next_m_s      = load_s ? pend_m_r : act_m_r;
        next_n_s      = load_s ? pend_n_r : act_n_r;
    end

    assign cfg_ready   = !pend_v_r;
    assign wave        = (state_r == ST_HIGH);
    assign busy        = (state_r != ST_IDLE);
    assign period_tick = period_tick_s;

    // Configuration slot, timebase counters and phase sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            ucnt_r   <= U_ZERO;
            pcnt_r   <= C_ZERO;
            act_m_r  <= C_ONE;
            act_n_r  <= C_ONE;
            pend_m_r <= C_ZERO;
            pend_n_r <= C_ZERO;
            pend_v_r <= 1'b0;
        end else begin
            act_m_r <= next_m_s;
            act_n_r <= next_n_s;
            if (accept_s) begin
                pend_m_r <= cfg_m;
                pend_n_r <= cfg_n;
                pend_v_r <= 1'b1;
            end else if (load_s) begin
                pend_v_r <= 1'b0;
            end

            if (stop) begin
                state_r <= ST_IDLE;
                ucnt_r  <= U_ZERO;
                pcnt_r  <= C_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // Start decision deliberately uses the lengths active this cycle
                        if (start) begin
                            ucnt_r <= U_ZERO;
                            pcnt_r <= C_ZERO;
                            if (act_m_r != C_ZERO) begin
                                state_r <= ST_HIGH;
                            end else if (act_n_r != C_ZERO) begin
                                state_r <= ST_LOW;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end
                    end
                    ST_HIGH, ST_LOW: begin
                        if (!unit_end_s) begin
                            ucnt_r <= ucnt_r + U_ONE;
                        end else begin
                            ucnt_r <= U_ZERO;
                            if (high_end_s && (act_n_r != C_ZERO)) begin
                                state_r <= ST_LOW;
                                pcnt_r  <= C_ZERO;
                            end else if (period_tick_s) begin
                                pcnt_r <= C_ZERO;
                                if (next_m_s != C_ZERO) begin
                                    state_r <= ST_HIGH;
                                end else if (next_n_s != C_ZERO) begin
                                    state_r <= ST_LOW;
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end else begin
                                pcnt_r <= pcnt_r + C_ONE;
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        ucnt_r  <= U_ZERO;
                        pcnt_r  <= C_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sqwave_ctrl.sv
// Directed bench for sqwave_ctrl (UNIT_CYCLES=10, CW=4) with hand-computed expected waveforms.
module tb_sqwave_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_m = 4'd0;
    logic [3:0] cfg_n = 4'd0;
    logic       cfg_ready;
    logic       wave;
    logic       busy;
    logic       period_tick;

    int tests_run = 0;
    int tests_failed = 0;
    int obs_high;
    int obs_tick;
    int obs_first;
    int obs_ready;

    sqwave_ctrl #(.UNIT_CYCLES(10), .CW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_m      (cfg_m),
        .cfg_n      (cfg_n),
        .cfg_ready  (cfg_ready),
        .wave       (wave),
        .busy       (busy),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Sample n consecutive cycles starting at the current one, then advance past them
    task automatic observe(input int n);
        obs_high = 0;
        obs_tick = 0;
        obs_first = 0;
        obs_ready = 0;
        for (int i = 1; i <= n; i++) begin
            if (wave === 1'b1) obs_high++;
            if (cfg_ready === 1'b1) obs_ready++;
            if (period_tick === 1'b1) begin
                obs_tick++;
                if (obs_first == 0) obs_first = i;
            end
            step();
        end
    endtask

    task automatic load_cfg(input logic [3:0] m, input logic [3:0] n);
        cfg_valid = 1'b1;
        cfg_m = m;
        cfg_n = n;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_wave", wave, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_tick", period_tick, 0);
        reset = 1'b0;
        step();

        // Basic waveform m=2 n=3, idle load takes one cycle
        cfg_valid = 1'b1;
        cfg_m = 4'd2;
        cfg_n = 4'd3;
        step();
        cfg_valid = 1'b0;
        chk("idle_accept_ready", cfg_ready, 0);
        step();
        chk("idle_load_ready", cfg_ready, 1);
        do_start();
        chk("start_wave", wave, 1);
        chk("start_busy", busy, 1);
        observe(20);
        chk("p1_high_len", obs_high, 20);
        chk("p1_high_ticks", obs_tick, 0);
        observe(30);
        chk("p1_low_high", obs_high, 0);
        chk("p1_tick_pos", obs_first, 30);
        chk("p1_tick_cnt", obs_tick, 1);
        observe(100);
        chk("p23_high", obs_high, 40);
        chk("p23_ticks", obs_tick, 2);
        chk("p23_tick_pos", obs_first, 50);

        // Mid-period reconfig at cycle 5 of period 4
        observe(4);
        chk("rc_ready_before", cfg_ready, 1);
        cfg_valid = 1'b1;
        cfg_m = 4'd1;
        cfg_n = 4'd1;
        step();
        chk("rc_ready_after", cfg_ready, 0);
        cfg_m = 4'd2;
        cfg_n = 4'd2;
        observe(45);
        chk("rc_stall_ready", obs_ready, 0);
        chk("rc_old_high", obs_high, 15);
        chk("rc_old_tick_pos", obs_first, 45);
        chk("rc_boundary_ready", cfg_ready, 1);
        chk("rc_boundary_wave", wave, 1);
        step();
        cfg_valid = 1'b0;
        chk("rc_second_accept", cfg_ready, 0);
        observe(19);
        chk("rc_new_high", obs_high, 9);
        chk("rc_new_tick_pos", obs_first, 19);
        chk("rc_new_ticks", obs_tick, 1);
        observe(40);
        chk("rc_second_high", obs_high, 20);
        chk("rc_second_tick_pos", obs_first, 40);
        do_stop();
        chk("rc_stop_busy", busy, 0);

        // Degenerate lengths
        load_cfg(4'd0, 4'd4);
        do_start();
        chk("m0_busy", busy, 1);
        observe(80);
        chk("m0_high", obs_high, 0);
        chk("m0_ticks", obs_tick, 2);
        chk("m0_tick_pos", obs_first, 40);
        do_stop();
        load_cfg(4'd3, 4'd0);
        do_start();
        observe(90);
        chk("n0_high", obs_high, 90);
        chk("n0_ticks", obs_tick, 3);
        chk("n0_tick_pos", obs_first, 30);
        do_stop();
        chk("n0_stop_wave", wave, 0);
        load_cfg(4'd0, 4'd0);
        do_start();
        chk("mn0_busy", busy, 0);
        observe(5);
        chk("mn0_idle_high", obs_high, 0);
        chk("mn0_busy_later", busy, 0);

        // Stop behaviour
        load_cfg(4'd2, 4'd3);
        do_start();
        observe(6);
        do_stop();
        chk("stop_wave", wave, 0);
        chk("stop_busy", busy, 0);
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_busy", busy, 0);
        do_start();
        observe(20);
        chk("restart_high", obs_high, 20);
        chk("restart_low_next", wave, 0);
        observe(30);
        chk("restart_tick_pos", obs_first, 30);

        // Reset mid-HIGH with a config pending
        cfg_valid = 1'b1;
        cfg_m = 4'd5;
        cfg_n = 4'd5;
        step();
        cfg_valid = 1'b0;
        chk("pre_rst_ready", cfg_ready, 0);
        observe(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_wave", wave, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cfg_ready, 1);
        chk("mid_rst_tick", period_tick, 0);
        do_start();
        observe(20);
        chk("post_rst_high", obs_high, 10);
        chk("post_rst_ticks", obs_tick, 1);
        chk("post_rst_tick_pos", obs_first, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
